cu_fsm: RTL and testbench

CU_FSM -- requirements
Module: cu_fsm

---
 rtl/cu_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_cu_fsm.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_fsm.sv
// cu_fsm -- multi-cycle instruction control unit.
// Accepts one opcode at a time in IDLE and walks it through
// DECODE / EXEC / MEM / WB.
// It drives the register-file, ALU, data-memory and mux controls for that
// instruction, plus the write strobes.
// Build option: define CU_MULDIV_STALL_EN to hold EXEC for MULDIV_CYCLES
// cycles on the multiply/divide opcodes (3, 4, 20, 21).
module cu_fsm #(
  parameter int OPCODE_W      = 6,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                equ,
  input  logic                les,
  output logic [2:0]          im_control,
  output logic [3:0]          alu_control,
  output logic                dm_control,
  output logic [6:0]          sel,
  output logic                rf_we,
  output logic                pc_we,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Idle/reset value of the mux selects; equals the decode of a plain op.
  localparam logic [6:0] SEL_RST    = 7'h5B;
  // Every illegal opcode is folded onto one code >= 32 so it decodes as NOP.
  localparam logic [5:0] OP_ILLEGAL = 6'h3F;
  // Stall counter preload: EXEC lasts MD_LAST+1 cycles.
  localparam logic [3:0] MD_LAST    = 4'(MULDIV_CYCLES - 1);
`ifdef CU_MULDIV_STALL_EN
  localparam logic       STALL_EN   = 1'b1;
`else
  localparam logic       STALL_EN   = 1'b0;
`endif

  state_t              state_reg;
  state_t              state_next;
  logic [5:0]          op_reg;
  logic [3:0]          cnt_reg;
  logic [2:0]          im_reg;
  logic [2:0]          im_dec;
  logic [3:0]          alu_reg;
  logic [3:0]          alu_dec;
  logic [6:0]          sel_reg;
  logic [6:0]          sel_dec;
  logic [OPCODE_W-1:0] upper_bits;
  logic                op_illegal;
  logic                accept;
  logic                is_alu;
  logic                is_mem;
  logic                is_store;
  logic                is_muldiv;
  logic                exec_stall;

  // Collect opcode bits above bit 5; any of them set makes the opcode illegal.
  genvar gi;
  generate
    for (gi = 0; gi < OPCODE_W; gi++) begin : g_upper
      if (gi < 6) begin : g_low
        assign upper_bits[gi] = 1'b0;
      end else begin : g_high
        assign upper_bits[gi] = opcode[gi];
      end
    end
  endgenerate

  assign op_illegal = (|upper_bits) | opcode[5];
  assign accept     = (state_reg == S_IDLE) & instr_valid;

  // Opcode classes, taken from the captured opcode.
  assign is_alu     = (op_reg >= 6'd1)  && (op_reg <= 6'd23);
  assign is_mem     = (op_reg >= 6'd24) && (op_reg <= 6'd27);
  assign is_store   = (op_reg == 6'd25) || (op_reg == 6'd27);
  assign is_muldiv  = (op_reg == 6'd3)  || (op_reg == 6'd4) ||
                      (op_reg == 6'd20) || (op_reg == 6'd21);
  assign exec_stall = STALL_EN & is_muldiv & (cnt_reg != 4'd0);

  assign im_control  = im_reg;
  assign alu_control = alu_reg;
  assign sel         = sel_reg;

  // Decode the captured opcode into the controls latched on the edge leaving DECODE.
  always_comb begin
    im_dec  = 3'b001;
    alu_dec = 4'd0;
    sel_dec = SEL_RST;
    if ((op_reg >= 6'd1) && (op_reg <= 6'd15)) begin
      im_dec[2:1] = 2'd2;
      alu_dec     = op_reg[3:0];
    end
    if (is_mem) begin
      im_dec[2:1] = 2'd1;
    end
    if ((op_reg >= 6'd28) && (op_reg <= 6'd31)) begin
      im_dec[0] = 1'b0;
    end
    case (op_reg)
      6'd16, 6'd17, 6'd18: alu_dec = 4'd1;
      6'd19:               alu_dec = 4'd2;
      6'd20:               alu_dec = 4'd3;
      6'd21:               alu_dec = 4'd4;
      6'd22:               alu_dec = 4'd9;
      6'd23:               alu_dec = 4'd10;
      default:             ;
    endcase
    if ((op_reg >= 6'd18) && (op_reg <= 6'd27)) begin
      sel_dec[3] = 1'b0;
    end
    if (op_reg == 6'd27) begin
      sel_dec[4] = 1'b0;
    end
    case (op_reg)
      6'd26:   sel_dec[6:5] = 2'd0;
      6'd17:   sel_dec[6:5] = 2'd1;
      6'd24:   sel_dec[6:5] = 2'd3;
      default: ;
    endcase
    // Branch outcome uses the compare flags present while in DECODE.
    case (op_reg)
      6'd0:    sel_dec[2:0] = 3'd4;
      6'd28:   sel_dec[2:0] = 3'd0;
      6'd29:   sel_dec[2:0] = 3'd2;
      6'd30:   sel_dec[2:0] = equ ? 3'd1 : 3'd3;
      6'd31:   sel_dec[2:0] = les ? 3'd1 : 3'd3;
      default: ;
    endcase
  end

  // State register; reset returns to IDLE immediately, even mid-instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe logic; pc_we marks the last non-IDLE cycle.
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    dm_control  = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        instr_ready = ~rst;
        if (instr_valid) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (op_reg == 6'd0) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (exec_stall) begin
          state_next = S_EXEC;
        end else if (is_mem) begin
          state_next = S_MEM;
        end else if (is_alu) begin
          state_next = S_WB;
        end else begin
          state_next = S_IDLE;
          pc_we      = 1'b1;
        end
      end
      S_MEM: begin
        if (is_store) begin
          dm_control = 1'b1;
          pc_we      = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        state_next = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the opcode, latch controls leaving DECODE, count a stalled EXEC,
  // and restore idle control values when the instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg  <= 6'd0;
      cnt_reg <= 4'd0;
      im_reg  <= 3'd0;
      alu_reg <= 4'd0;
      sel_reg <= SEL_RST;
    end else begin
      if (accept) begin
        op_reg <= op_illegal ? OP_ILLEGAL : opcode[5:0];
      end
      if (state_reg == S_DECODE) begin
        im_reg  <= im_dec;
        alu_reg <= alu_dec;
        sel_reg <= sel_dec;
        cnt_reg <= MD_LAST;
      end else if ((state_reg == S_EXEC) && exec_stall) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if ((state_reg != S_IDLE) && (state_next == S_IDLE)) begin
        im_reg  <= 3'd0;
        alu_reg <= 4'd0;
        sel_reg <= SEL_RST;
      end
    end
  end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm -- directed bench for cu_fsm (OPCODE_W=8 so upper opcode bits exist).
// Period k is the clock period that starts at the k-th rising edge after the
// accept edge; k=0 is DECODE.
// A strobe that fires "at cycle N" is high in period N-1 and takes effect on
// edge N.
// Trace vectors hold one bit per period: bit k = value during period k.
`timescale 1ns/1ps
module tb_cu_fsm;

  localparam int OPCODE_W      = 8;
  localparam int MULDIV_CYCLES = 4;
`ifdef CU_MULDIV_STALL_EN
  localparam logic [7:0] MD_RF  = 8'h20;
  localparam logic [7:0] MD_RDY = 8'hC0;
`else
  localparam logic [7:0] MD_RF  = 8'h04;
  localparam logic [7:0] MD_RDY = 8'hF8;
`endif

  typedef struct packed {
    logic [7:0] op;
    logic       e;
    logic       l;
    logic [2:0] im;
    logic [3:0] alu;
    logic [6:0] sel;
    logic [7:0] rf;
    logic [7:0] pc;
    logic [7:0] dm;
    logic [7:0] rdy;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                instr_ready;
  logic                equ;
  logic                les;
  logic [2:0]          im_control;
  logic [3:0]          alu_control;
  logic                dm_control;
  logic [6:0]          sel;
  logic                rf_we;
  logic                pc_we;
  logic                halted;

  int checks;
  int failures;

  cu_fsm #(
    .OPCODE_W      (OPCODE_W),
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .equ         (equ),
    .les         (les),
    .im_control  (im_control),
    .alu_control (alu_control),
    .dm_control  (dm_control),
    .sel         (sel),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Issue one opcode from IDLE (called at posedge+1) and record 8 periods.
  task automatic run_instr(input logic [7:0] op, input logic e, input logic l,
                           output logic [7:0] rf_t, output logic [7:0] pc_t,
                           output logic [7:0] dm_t, output logic [7:0] rdy_t,
                           output logic [2:0] im_x, output logic [3:0] alu_x,
                           output logic [6:0] sel_x);
    opcode      = op;
    equ         = e;
    les         = l;
    instr_valid = 1'b1;
    im_x  = 3'd0;
    alu_x = 4'd0;
    sel_x = 7'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rf_t[k]  = rf_we;
      pc_t[k]  = pc_we;
      dm_t[k]  = dm_control;
      rdy_t[k] = instr_ready;
      if (k == 1) begin
        im_x  = im_control;
        alu_x = alu_control;
        sel_x = sel;
      end
      @(posedge clk); #1;
    end
    $display("txn op=0x%02h equ=%0d les=%0d im=%b alu=%0d sel=0x%02h rf=%b pc=%b dm=%b rdy=%b",
             op, e, l, im_x, alu_x, sel_x, rf_t, pc_t, dm_t, rdy_t);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; equ = 1'b0; les = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", instr_ready);
    end
    checks++;
    if ({im_control, alu_control, sel} !== {3'd0, 4'd0, 7'h5B}) begin
      failures++;
      $display("FAIL reset_controls got im=%b alu=%0d sel=0x%02h exp im=000 alu=0 sel=0x5b",
               im_control, alu_control, sel);
    end
    checks++;
    if ({dm_control, rf_we, pc_we, halted} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got dm/rf/pc/halted=%b exp=0000",
               {dm_control, rf_we, pc_we, halted});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", instr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    vec_t tbl [6];
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    tbl[0] = '{8'd1,  1'b0, 1'b0, 3'b101, 4'd1,  7'h5B, 8'h04, 8'h04, 8'h00, 8'hF8};
    tbl[1] = '{8'd15, 1'b0, 1'b0, 3'b101, 4'd15, 7'h5B, 8'h04, 8'h04, 8'h00, 8'hF8};
    tbl[2] = '{8'd17, 1'b0, 1'b0, 3'b001, 4'd1,  7'h3B, 8'h04, 8'h04, 8'h00, 8'hF8};
    tbl[3] = '{8'd19, 1'b0, 1'b0, 3'b001, 4'd2,  7'h53, 8'h04, 8'h04, 8'h00, 8'hF8};
    tbl[4] = '{8'd22, 1'b0, 1'b0, 3'b001, 4'd9,  7'h53, 8'h04, 8'h04, 8'h00, 8'hF8};
    tbl[5] = '{8'd23, 1'b0, 1'b0, 3'b001, 4'd10, 7'h53, 8'h04, 8'h04, 8'h00, 8'hF8};
    for (int i = 0; i < 6; i++) begin
      run_instr(tbl[i].op, tbl[i].e, tbl[i].l, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
      checks++;
      if ({im_x, alu_x, sel_x} !== {tbl[i].im, tbl[i].alu, tbl[i].sel}) begin
        failures++;
        $display("FAIL alu_controls op=%0d got=0x%04h exp=0x%04h", tbl[i].op,
                 {im_x, alu_x, sel_x}, {tbl[i].im, tbl[i].alu, tbl[i].sel});
      end
      checks++;
      if ({rf_t, pc_t, dm_t, rdy_t} !== {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy}) begin
        failures++;
        $display("FAIL alu_trace op=%0d got rf/pc/dm/rdy=0x%08h exp=0x%08h", tbl[i].op,
                 {rf_t, pc_t, dm_t, rdy_t}, {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy});
      end
    end
    checks++;
    if ({im_control, alu_control, sel} !== {3'd0, 4'd0, 7'h5B}) begin
      failures++;
      $display("FAIL idle_controls got im=%b alu=%0d sel=0x%02h exp im=000 alu=0 sel=0x5b",
               im_control, alu_control, sel);
    end
  endtask

  task automatic test_mem_ops();
    vec_t tbl [4];
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    tbl[0] = '{8'd24, 1'b0, 1'b0, 3'b011, 4'd0, 7'h73, 8'h08, 8'h08, 8'h00, 8'hF0};
    tbl[1] = '{8'd26, 1'b0, 1'b0, 3'b011, 4'd0, 7'h13, 8'h08, 8'h08, 8'h00, 8'hF0};
    tbl[2] = '{8'd25, 1'b0, 1'b0, 3'b011, 4'd0, 7'h53, 8'h00, 8'h04, 8'h04, 8'hF8};
    tbl[3] = '{8'd27, 1'b0, 1'b0, 3'b011, 4'd0, 7'h43, 8'h00, 8'h04, 8'h04, 8'hF8};
    for (int i = 0; i < 4; i++) begin
      run_instr(tbl[i].op, tbl[i].e, tbl[i].l, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
      checks++;
      if ({im_x, alu_x, sel_x} !== {tbl[i].im, tbl[i].alu, tbl[i].sel}) begin
        failures++;
        $display("FAIL mem_controls op=%0d got=0x%04h exp=0x%04h", tbl[i].op,
                 {im_x, alu_x, sel_x}, {tbl[i].im, tbl[i].alu, tbl[i].sel});
      end
      checks++;
      if ({rf_t, pc_t, dm_t, rdy_t} !== {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy}) begin
        failures++;
        $display("FAIL mem_trace op=%0d got rf/pc/dm/rdy=0x%08h exp=0x%08h", tbl[i].op,
                 {rf_t, pc_t, dm_t, rdy_t}, {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy});
      end
    end
  endtask

  task automatic test_branch_ops();
    vec_t tbl [6];
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    tbl[0] = '{8'd28, 1'b0, 1'b0, 3'b000, 4'd0, 7'h58, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[1] = '{8'd29, 1'b0, 1'b0, 3'b000, 4'd0, 7'h5A, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[2] = '{8'd30, 1'b1, 1'b0, 3'b000, 4'd0, 7'h59, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[3] = '{8'd30, 1'b0, 1'b1, 3'b000, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[4] = '{8'd31, 1'b0, 1'b1, 3'b000, 4'd0, 7'h59, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[5] = '{8'd31, 1'b1, 1'b0, 3'b000, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    for (int i = 0; i < 6; i++) begin
      run_instr(tbl[i].op, tbl[i].e, tbl[i].l, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
      checks++;
      if ({im_x, alu_x, sel_x} !== {tbl[i].im, tbl[i].alu, tbl[i].sel}) begin
        failures++;
        $display("FAIL branch_controls op=%0d equ=%0d les=%0d got=0x%04h exp=0x%04h",
                 tbl[i].op, tbl[i].e, tbl[i].l,
                 {im_x, alu_x, sel_x}, {tbl[i].im, tbl[i].alu, tbl[i].sel});
      end
      checks++;
      if ({rf_t, pc_t, dm_t, rdy_t} !== {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy}) begin
        failures++;
        $display("FAIL branch_trace op=%0d got rf/pc/dm/rdy=0x%08h exp=0x%08h", tbl[i].op,
                 {rf_t, pc_t, dm_t, rdy_t}, {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy});
      end
    end
  endtask

  task automatic test_muldiv_ops();
    vec_t tbl [4];
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    tbl[0] = '{8'd3,  1'b0, 1'b0, 3'b101, 4'd3, 7'h5B, MD_RF, MD_RF, 8'h00, MD_RDY};
    tbl[1] = '{8'd4,  1'b0, 1'b0, 3'b101, 4'd4, 7'h5B, MD_RF, MD_RF, 8'h00, MD_RDY};
    tbl[2] = '{8'd20, 1'b0, 1'b0, 3'b001, 4'd3, 7'h53, MD_RF, MD_RF, 8'h00, MD_RDY};
    tbl[3] = '{8'd21, 1'b0, 1'b0, 3'b001, 4'd4, 7'h53, MD_RF, MD_RF, 8'h00, MD_RDY};
    for (int i = 0; i < 4; i++) begin
      run_instr(tbl[i].op, tbl[i].e, tbl[i].l, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
      checks++;
      if ({im_x, alu_x, sel_x} !== {tbl[i].im, tbl[i].alu, tbl[i].sel}) begin
        failures++;
        $display("FAIL muldiv_controls op=%0d got=0x%04h exp=0x%04h", tbl[i].op,
                 {im_x, alu_x, sel_x}, {tbl[i].im, tbl[i].alu, tbl[i].sel});
      end
      checks++;
      if ({rf_t, pc_t, dm_t, rdy_t} !== {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy}) begin
        failures++;
        $display("FAIL muldiv_trace op=%0d got rf/pc/dm/rdy=0x%08h exp=0x%08h", tbl[i].op,
                 {rf_t, pc_t, dm_t, rdy_t}, {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy});
      end
    end
  endtask

  task automatic test_illegal();
    vec_t tbl [5];
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    tbl[0] = '{8'h21, 1'b0, 1'b0, 3'b001, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[1] = '{8'h3F, 1'b1, 1'b1, 3'b001, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[2] = '{8'h41, 1'b0, 1'b0, 3'b001, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[3] = '{8'h40, 1'b0, 1'b0, 3'b001, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    tbl[4] = '{8'hD9, 1'b0, 1'b0, 3'b001, 4'd0, 7'h5B, 8'h00, 8'h02, 8'h00, 8'hFC};
    for (int i = 0; i < 5; i++) begin
      run_instr(tbl[i].op, tbl[i].e, tbl[i].l, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
      checks++;
      if ({im_x, alu_x, sel_x} !== {tbl[i].im, tbl[i].alu, tbl[i].sel}) begin
        failures++;
        $display("FAIL illegal_controls op=0x%02h got=0x%04h exp=0x%04h", tbl[i].op,
                 {im_x, alu_x, sel_x}, {tbl[i].im, tbl[i].alu, tbl[i].sel});
      end
      checks++;
      if ({rf_t, pc_t, dm_t, rdy_t} !== {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy}) begin
        failures++;
        $display("FAIL illegal_trace op=0x%02h got rf/pc/dm/rdy=0x%08h exp=0x%08h", tbl[i].op,
                 {rf_t, pc_t, dm_t, rdy_t}, {tbl[i].rf, tbl[i].pc, tbl[i].dm, tbl[i].rdy});
      end
      checks++;
      if (halted !== 1'b0) begin
        failures++; $display("FAIL illegal_halted op=0x%02h got=%b exp=0", tbl[i].op, halted);
      end
    end
  endtask

  task automatic test_back_to_back();
    opcode = 8'd1; equ = 1'b0; les = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1;
    opcode = 8'd28;
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_busy_ready got=%b exp=0", instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({alu_control, sel} !== {4'd1, 7'h5B}) begin
      failures++;
      $display("FAIL b2b_first_controls got alu=%0d sel=0x%02h exp alu=1 sel=0x5b",
               alu_control, sel);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_we !== 1'b1) begin
      failures++; $display("FAIL b2b_first_rf_we got=%b exp=1", rf_we);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_idle_ready got=%b exp=1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_second_accept got ready=%b exp=0", instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({sel, pc_we} !== {7'h58, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second_exec got sel=0x%02h pc_we=%b exp sel=0x58 pc_we=1", sel, pc_we);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_second_done got ready=%b exp=1", instr_ready);
    end
    $display("txn back_to_back op=1 then op=28");
  endtask

  task automatic test_reset_mid();
    logic seen;
    opcode = 8'd25; equ = 1'b0; les = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dm_control !== 1'b1) begin
      failures++; $display("FAIL midrst_mem_dm got=%b exp=1", dm_control);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dm_control, pc_we} !== 2'b00) begin
      failures++; $display("FAIL midrst_drop got dm/pc=%b exp=00", {dm_control, pc_we});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_idle got ready=%b exp=1", instr_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      seen = seen | pc_we | dm_control | rf_we;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL midrst_late_strobe got=%b exp=0", seen);
    end
    $display("txn reset_during_mem op=25");
  endtask

  task automatic test_halt();
    logic [7:0] rf_t, pc_t, dm_t, rdy_t;
    logic [2:0] im_x;
    logic [3:0] alu_x;
    logic [6:0] sel_x;
    logic       stuck_bad;
    run_instr(8'd0, 1'b0, 1'b0, rf_t, pc_t, dm_t, rdy_t, im_x, alu_x, sel_x);
    checks++;
    if ({rf_t, pc_t, dm_t, rdy_t} !== 32'h0) begin
      failures++;
      $display("FAIL halt_trace got rf/pc/dm/rdy=0x%08h exp=0x00000000", {rf_t, pc_t, dm_t, rdy_t});
    end
    checks++;
    if ({im_x, alu_x, sel_x} !== {3'b001, 4'd0, 7'h5C}) begin
      failures++;
      $display("FAIL halt_controls got=0x%04h exp=0x%04h", {im_x, alu_x, sel_x},
               {3'b001, 4'd0, 7'h5C});
    end
    stuck_bad = 1'b0;
    opcode = 8'd1; instr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if ((instr_ready !== 1'b0) || (halted !== 1'b1)) stuck_bad = 1'b1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    checks++;
    if (stuck_bad !== 1'b0) begin
      failures++; $display("FAIL halt_stuck got leave=%b exp=0", stuck_bad);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({halted, instr_ready, im_control, alu_control, sel, pc_we} !==
        {1'b0, 1'b0, 3'd0, 4'd0, 7'h5B, 1'b0}) begin
      failures++;
      $display("FAIL halt_reset got halted=%b ready=%b im=%b alu=%0d sel=0x%02h pc=%b exp 0 0 000 0 0x5b 0",
               halted, instr_ready, im_control, alu_control, sel, pc_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({instr_ready, halted} !== 2'b10) begin
      failures++; $display("FAIL halt_release got ready/halted=%b exp=10", {instr_ready, halted});
    end
    @(posedge clk); #1;
    $display("txn halt op=0 then reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu_ops();
    test_mem_ops();
    test_branch_ops();
    test_muldiv_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
